// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared definitions for the sprite image loader: FSM state encoding and
// default image geometry. The display read path uses the same geometry, so
// both sides agree on the raster address map (row*WIDTH + col).
// No ports.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sprite_state_t;

    localparam int SPRITE_WIDTH  = 128;
    localparam int SPRITE_HEIGHT = 256;
    localparam int SPRITE_ADDR_W = 15;
    localparam int PIX_W         = 8;

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen
// Raster write-address generator. Tracks col/row and a running row base so
// the address is built by addition only (base += WIDTH on each row wrap).
// Ports:
//   pixel_clk  in   clock
//   reset_n    in   async active-low reset
//   advance    in   step to the next pixel
//   clear      in   return counters to pixel 0 (wins over advance)
//   waddr      out  base + col for the current pixel
//   last       out  current pixel is the final one of the image
// Advancing past the last pixel also returns the counters to 0.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int WIDTH  = SPRITE_WIDTH,
    parameter int HEIGHT = SPRITE_HEIGHT,
    parameter int ADDR_W = SPRITE_ADDR_W
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              clear,
    output logic [ADDR_W-1:0] waddr,
    output logic              last
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] base_q;
    logic              col_end;
    logic              row_end;

    assign col_end = (col_q == COL_W'(WIDTH - 1));
    assign row_end = (row_q == ROW_W'(HEIGHT - 1));
    assign last    = col_end & row_end;
    assign waddr   = base_q + ADDR_W'(col_q);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else if (clear || (advance && last)) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else if (advance) begin
            if (col_end) begin
                col_q  <= '0;
                row_q  <= row_q + ROW_W'(1);
                base_q <= base_q + ADDR_W'(WIDTH);
            end else begin
                col_q  <= col_q + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_loader.sv
// sprite_loader
// Writer side of the sprite RAM: accepts 8-bit palette indices over a
// valid/ready handshake and writes one full WIDTH x HEIGHT image in raster
// order into the RAM write port, one cycle after each accepted byte.
// Optional feature macro: SPRITE_LOADER_CHECKSUM_EN
//   defined   : an extra trailing byte is compared with the mod-256 sum of
//               the pixels; chk_err reports a mismatch.
//   undefined : LOAD goes straight to DONE, chk_err is tied low.
// Ports:
//   pixel_clk  in   clock
//   reset_n    in   async active-low reset
//   start      in   begin a load (only honoured in IDLE)
//   abort      in   cancel a load, back to IDLE without done
//   in_data    in   pixel byte
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted this cycle if in_valid
//   we         out  RAM write enable
//   waddr      out  RAM write address (row*WIDTH + col)
//   wdata      out  RAM write data
//   busy       out  load in progress (LOAD/CHECK/DONE)
//   done       out  one-cycle pulse, image written
//   chk_err    out  checksum mismatch from the last load
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting pixel bytes and writing them to RAM
// CHECK | accepting the checksum byte (checksum build only)
// DONE  | single-cycle completion pulse
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int WIDTH  = SPRITE_WIDTH,
    parameter int HEIGHT = SPRITE_HEIGHT,
    parameter int ADDR_W = SPRITE_ADDR_W
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [PIX_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              chk_err
);

    sprite_state_t     state_q;
    sprite_state_t     state_d;
    logic              start_ok;
    logic              xfer;
    logic              advance;
    logic              last_pix;
    logic [ADDR_W-1:0] gen_waddr;

    // Handshake decoded purely from registered state: no in_valid -> in_ready path.
    assign in_ready = (state_q == LOAD) || (state_q == CHECK);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    assign start_ok = (state_q == IDLE) && start && !abort;
    assign xfer     = in_valid && in_ready;
    // A byte handed over in the same cycle as abort is dropped.
    assign advance  = xfer && (state_q == LOAD) && !abort;

    sprite_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .advance   (advance),
        .clear     (start_ok || abort),
        .waddr     (gen_waddr),
        .last      (last_pix)
    );

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (advance && last_pix) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SPRITE_LOADER_CHECKSUM_EN
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM write port: registered, one cycle behind the accepted byte.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= advance;
            if (advance) begin
                waddr <= gen_waddr;
                wdata <= in_data;
            end
        end
    end

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [PIX_W-1:0] sum_q;
    logic             chk_err_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                sum_q     <= '0;
                chk_err_q <= 1'b0;
            end else begin
                if (advance) begin
                    sum_q <= sum_q + in_data;
                end
                if ((state_q == CHECK) && xfer && !abort) begin
                    chk_err_q <= (in_data != sum_q);
                end
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader
// Directed bench for sprite_loader. Three instances with different geometry:
//   [0] 4x2 (full load, back-pressure, abort, reset)
//   [1] 3x2 (row wrap)
//   [2] 2x2 (checksum byte handling)
// Follows SPRITE_LOADER_CHECKSUM_EN the same way the design does.
// Inputs are driven and outputs sampled on the falling edge.
module tb_sprite_loader;

`ifdef SPRITE_LOADER_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [2:0]  start, abort, valid, ready, we, busy, done, chk;
    logic [7:0]  data  [3];
    logic [7:0]  wdata [3];
    logic [14:0] waddr [3];

    int n_checks = 0;
    int n_fail   = 0;

    int sel = 0;
    int wr_addr[$];
    int wr_data[$];
    int busy_cnt  = 0;
    int done_cnt  = 0;
    int done_addr = -2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sprite_loader #(.WIDTH(4), .HEIGHT(2), .ADDR_W(15)) u_a (
        .pixel_clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
        .in_data(data[0]), .in_valid(valid[0]), .in_ready(ready[0]), .we(we[0]),
        .waddr(waddr[0]), .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .chk_err(chk[0]));

    sprite_loader #(.WIDTH(3), .HEIGHT(2), .ADDR_W(15)) u_b (
        .pixel_clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
        .in_data(data[1]), .in_valid(valid[1]), .in_ready(ready[1]), .we(we[1]),
        .waddr(waddr[1]), .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .chk_err(chk[1]));

    sprite_loader #(.WIDTH(2), .HEIGHT(2), .ADDR_W(15)) u_c (
        .pixel_clk(clk), .reset_n(reset_n), .start(start[2]), .abort(abort[2]),
        .in_data(data[2]), .in_valid(valid[2]), .in_ready(ready[2]), .we(we[2]),
        .waddr(waddr[2]), .wdata(wdata[2]), .busy(busy[2]), .done(done[2]), .chk_err(chk[2]));

    // Write/status monitor for the instance under test.
    always @(negedge clk) begin
        if (reset_n) begin
            if (we[sel]) begin
                wr_addr.push_back(int'(waddr[sel]));
                wr_data.push_back(int'(wdata[sel]));
            end
            if (busy[sel]) busy_cnt++;
            if (done[sel]) begin
                done_cnt++;
                done_addr = we[sel] ? int'(waddr[sel]) : -1;
            end
        end
    end

    task automatic clear_mon(input int i);
        sel = i;
        wr_addr.delete();
        wr_data.delete();
        busy_cnt  = 0;
        done_cnt  = 0;
        done_addr = -2;
    endtask

    // One load on instance i. In the checksum build the trailing byte `extra`
    // follows the pixels. abort_at >= 0 aborts after that many bytes.
    task automatic run_load(input int i, input int nbytes, input bit toggle,
                            input int abort_at, input logic [7:0] first,
                            input logic [7:0] extra);
        int sent = 0;
        int cyc = 0;
        int total;
        bit aborted = 0;
        total = nbytes + CHK;
        clear_mon(i);
        @(negedge clk); start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;
        while (cyc < 200) begin
            if (abort_at >= 0 && sent == abort_at) begin
                valid[i] = 1'b0;
                abort[i] = 1'b1;
                @(negedge clk);
                abort[i] = 1'b0;
                aborted = 1;
                break;
            end
            if (sent >= total) break;
            valid[i] = toggle ? (cyc % 2 == 0) : 1'b1;
            data[i]  = (sent >= nbytes) ? extra : first + 8'(sent);
            if (valid[i] && ready[i]) sent++;
            @(negedge clk);
            cyc++;
        end
        valid[i] = 1'b0;
        n_checks++;
        if (!aborted && sent < total) begin
            n_fail++;
            $display("FAIL load_timeout inst=%0d sent=%0d required=%0d", i, sent, total);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({ready[0], we[0], busy[0], done[0], chk[0]} !== 5'b0 || waddr[0] !== 15'd0 || wdata[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values got rdy=%b we=%b busy=%b done=%b chk=%b addr=%0d data=%0d required all 0",
                     ready[0], we[0], busy[0], done[0], chk[0], waddr[0], wdata[0]);
        end
        reset_n = 1'b1;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0; valid[0] = 1'b1; data[0] = 8'd5;
        @(negedge clk); data[0] = 8'd6;
        @(negedge clk);
        n_checks++;
        if (we[0] !== 1'b1 || waddr[0] !== 15'd1 || wdata[0] !== 8'd6 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_write got we=%b addr=%0d data=%0d busy=%b required 1/1/6/1",
                     we[0], waddr[0], wdata[0], busy[0]);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ready[0], we[0], busy[0], done[0]} !== 4'b0 || waddr[0] !== 15'd0 || wdata[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset got rdy=%b we=%b busy=%b done=%b addr=%0d data=%0d required all 0",
                     ready[0], we[0], busy[0], done[0], waddr[0], wdata[0]);
        end
        valid[0] = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        run_load(0, 8, 1'b0, -1, 8'h00, 8'h1C);
        n_checks++;
        if (wr_addr.size() != 8) begin
            n_fail++;
            $display("FAIL full_write_count got %0d required 8", wr_addr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (wr_addr[k] != k || wr_data[k] != k) begin
                    n_fail++;
                    $display("FAIL full_write[%0d] got addr=%0d data=%0d required %0d/%0d",
                             k, wr_addr[k], wr_data[k], k, k);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_addr != (CHK ? -1 : 7)) begin
            n_fail++;
            $display("FAIL full_done got pulses=%0d addr=%0d required 1/%0d", done_cnt, done_addr, CHK ? -1 : 7);
        end
        n_checks++;
        if (busy_cnt != (CHK ? 10 : 9)) begin
            n_fail++;
            $display("FAIL full_busy_cycles got %0d required %0d", busy_cnt, CHK ? 10 : 9);
        end
        n_checks++;
        if (busy[0] !== 1'b0 || chk[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end_state got busy=%b chk=%b required 0/0", busy[0], chk[0]);
        end
    endtask

    task automatic test_back_pressure();
        run_load(0, 8, 1'b1, -1, 8'h80, 8'h1C);
        n_checks++;
        if (wr_addr.size() != 8) begin
            n_fail++;
            $display("FAIL bp_write_count got %0d required 8", wr_addr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (wr_addr[k] != k || wr_data[k] != 8'h80 + k) begin
                    n_fail++;
                    $display("FAIL bp_write[%0d] got addr=%0d data=%0d required %0d/%0d",
                             k, wr_addr[k], wr_data[k], k, 8'h80 + k);
                end
            end
        end
        n_checks++;
        if (busy_cnt != (CHK ? 18 : 16) || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_busy_done got busy=%0d done=%0d required %0d/1", busy_cnt, done_cnt, CHK ? 18 : 16);
        end
    endtask

    task automatic test_row_wrap();
        run_load(1, 6, 1'b0, -1, 8'd10, 8'h4B);
        n_checks++;
        if (wr_addr.size() != 6) begin
            n_fail++;
            $display("FAIL wrap_write_count got %0d required 6", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[3] != 3 || wr_data[3] != 13) begin
                n_fail++;
                $display("FAIL wrap_row1_col0 got addr=%0d data=%0d required 3/13", wr_addr[3], wr_data[3]);
            end
            n_checks++;
            if (wr_addr[5] != 5 || wr_data[5] != 15) begin
                n_fail++;
                $display("FAIL wrap_last got addr=%0d data=%0d required 5/15", wr_addr[5], wr_data[5]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_done got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_abort();
        run_load(0, 8, 1'b0, 3, 8'h40, 8'h00);
        n_checks++;
        if (wr_addr.size() != 3) begin
            n_fail++;
            $display("FAIL abort_write_count got %0d required 3", wr_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (wr_addr[k] != k || wr_data[k] != 8'h40 + k) begin
                    n_fail++;
                    $display("FAIL abort_write[%0d] got addr=%0d data=%0d required %0d/%0d",
                             k, wr_addr[k], wr_data[k], k, 8'h40 + k);
                end
            end
        end
        n_checks++;
        if (done_cnt != 0 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got done=%0d busy=%b rdy=%b required 0/0/0", done_cnt, busy[0], ready[0]);
        end
        run_load(0, 8, 1'b0, -1, 8'h20, 8'h1C);
        n_checks++;
        if (wr_addr.size() != 8 || wr_addr[0] != 0 || wr_addr[7] != 7 || wr_data[0] != 8'h20 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL reload_after_abort got n=%0d first=%0d data0=%0d done=%0d required 8/0/32/1",
                     wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : -1,
                     wr_data.size() > 0 ? wr_data[0] : -1, done_cnt);
        end
    endtask

    task automatic test_start_abort_same();
        clear_mon(0);
        @(negedge clk); start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0; abort[0] = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_same got busy=%b rdy=%b required 0/0", busy[0], ready[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_checksum();
        run_load(2, 4, 1'b0, -1, 8'd1, 8'h0A);
        n_checks++;
        if (wr_addr.size() != 4 || wr_addr[3] != 3 || wr_data[3] != 4) begin
            n_fail++;
            $display("FAIL chk_good_writes got n=%0d required 4 ending addr3/data4", wr_addr.size());
        end
        n_checks++;
        if (chk[2] !== 1'b0 || done_cnt != 1 || done_addr != (CHK ? -1 : 3)) begin
            n_fail++;
            $display("FAIL chk_good got chk=%b done=%0d daddr=%0d required 0/1/%0d",
                     chk[2], done_cnt, done_addr, CHK ? -1 : 3);
        end
        run_load(2, 4, 1'b0, -1, 8'd1, 8'h0B);
        n_checks++;
        if (chk[2] !== 1'(CHK) || wr_addr.size() != 4) begin
            n_fail++;
            $display("FAIL chk_bad got chk=%b writes=%0d required %0d/4", chk[2], wr_addr.size(), CHK);
        end
        clear_mon(2);
        @(negedge clk); start[2] = 1'b1;
        @(negedge clk); start[2] = 1'b0; abort[2] = 1'b1;
        n_checks++;
        if (chk[2] !== 1'b0 || busy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_clear_on_start got chk=%b busy=%b required 0/1", chk[2], busy[2]);
        end
        @(negedge clk); abort[2] = 1'b0;
        n_checks++;
        if (busy[2] !== 1'b0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL chk_abort got busy=%b done=%0d required 0/0", busy[2], done_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start = '0;
        abort = '0;
        valid = '0;
        for (int k = 0; k < 3; k++) data[k] = 8'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_full_load();
        test_back_pressure();
        test_row_wrap();
        test_abort();
        test_start_abort_same();
        test_checksum();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
